eth_tx_arb: RTL and testbench
=============================

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 SHALL have parameters: MIN_LEN, default 60, minimum frame bytes before FCS (short frames zero-padded); MAX_LEN, default 1514, maximum frame bytes before FCS; PEND_MAX, default 15, maximum frames pending in FIFO.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have: req_in in 2, requester i wants to send a frame; grant_out out 2, one-hot, requester i owns the TX path.
REQ-004 SHALL have: d0_in in 8 and d1_in in 8, payload bytes of requesters 0/1; valid_in in 2, byte valid; last_in in 2, byte is final; abort_in in 2, cancel the current frame.
REQ-005 SHALL have: ack_out out 2, byte of requester i consumed this cycle.
REQ-006 SHALL have the MAC TX FIFO write side: wr_en_out out 1; wr_d_out out 9, bit8 = control flag; wr_full_in in 1.
REQ-007 SHALL have: mac_sof_rd_in in 1, one-cycle pulse when the MAC reads a SOF control word; mac_start_out out 1, start enable to the MAC.

Function
REQ-008 SHALL use control words 9'h100 = SOF, 9'h101 = EOF, 9'h103 = ERR, and data words {1'b0, byte}.
REQ-009 SHALL assert wr_en_out only when wr_full_in is low in the same cycle; a word is written exactly when wr_en_out=1.
REQ-010 SHALL use states IDLE, SOF, DATA, PAD, EOF, ERR, DROP.
REQ-011 IDLE: if any req_in bit is set and pending < PEND_MAX, SHALL grant round-robin. A single requester wins outright. With both requesting, the requester not granted last wins; pointer resets to favour requester 0. The state then goes to SOF and grant_out is registered (one cycle after the decision).
REQ-012 SOF: SHALL write 9'h100, clear byte counter (11-bit), go to DATA.
REQ-013 DATA: with granted valid=1 and !wr_full_in, SHALL write the data word, pulse ack_out for that requester and increment the counter. With valid=0 or full, nothing is written and no ack is given.
REQ-014 DATA on accepted last byte: SHALL go to PAD if counter+1 < MIN_LEN, else to EOF.
REQ-015 DATA: abort_in of the granted requester SHALL go to ERR without accepting that cycle's byte; abort takes priority over valid and last.
REQ-016 DATA: an accepted byte that is not last and makes the counter equal MAX_LEN SHALL go to ERR, then to DROP.
REQ-017 DROP: SHALL ack every valid byte of the granted requester without writing; after the last byte is acked, go to IDLE.
REQ-018 PAD: SHALL write 9'h000 per non-full cycle until counter = MIN_LEN, then go to EOF.
REQ-019 EOF: SHALL write 9'h101 when not full, then go to IDLE.
REQ-020 ERR: SHALL write 9'h103 when not full. Next state is DROP if entered via the length limit, else IDLE.
REQ-021 grant_out SHALL stay asserted from the IDLE decision until the cycle the state returns to IDLE; req_in deassertion mid-frame is ignored.
REQ-022 SHALL keep a 4-bit pending counter: +1 on writing EOF or ERR, -1 on mac_sof_rd_in, unchanged on both together. Underflow SHALL be blocked (decrement at 0 ignored).
REQ-023 mac_start_out SHALL be registered, equal to (pending != 0).
REQ-024 ack_out and wr_en_out SHALL be combinational from state, valid_in and wr_full_in; all else registered.

Reset
REQ-025 On rst=1 at a clock edge: state IDLE, grant_out=0, wr_en_out=0, wr_d_out=0, ack_out=0, mac_start_out=0, pending=0, counter=0, round-robin favours requester 0; an in-progress frame is discarded with no EOF/ERR written.

Verification
REQ-026 Requester 0 sends 64 bytes 0x00..0x3F, FIFO never full -> FIFO gets 9'h100, 64 data words, 9'h101; mac_start_out=1 the cycle after the EOF write.
REQ-027 Requester 1 sends 10-byte frame -> 9'h100, 10 data words, 50 x 9'h000, 9'h101 (62 words total).
REQ-028 Both req_in held, each sends 3 frames -> grants alternate 0,1,0,1,0,1.
REQ-029 Abort asserted on the 5th byte -> 9'h100, 4 data, 9'h103; abort-cycle byte not acked; return to IDLE.
REQ-030 Requester streams 1600 bytes -> 9'h100, 1514 data, 9'h103; remaining 86 bytes acked, not written.
REQ-031 wr_full_in toggled every cycle during a frame, with mac_sof_rd_in pulsed in the same cycle as the EOF write -> no word lost or duplicated; pending unchanged in that cycle.

Source files
------------

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: two-requester frame arbiter feeding a MAC TX FIFO.
// Frames are wrapped in SOF/EOF control words, zero-padded up to MIN_LEN,
// truncated with an ERR word at MAX_LEN (remaining bytes drained silently),
// and a pending-frame count gates new grants and drives the MAC start enable.
module eth_tx_arb #(
    parameter int unsigned MIN_LEN  = 60,
    parameter int unsigned MAX_LEN  = 1514,
    parameter int unsigned PEND_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_in,
    output logic [1:0] grant_out,
    input  logic [7:0] d0_in,
    input  logic [7:0] d1_in,
    input  logic [1:0] valid_in,
    input  logic [1:0] last_in,
    input  logic [1:0] abort_in,
    output logic [1:0] ack_out,
    output logic       wr_en_out,
    output logic [8:0] wr_d_out,
    input  logic       wr_full_in,
    input  logic       mac_sof_rd_in,
    output logic       mac_start_out
);

    localparam logic [8:0]  SOF_W      = 9'h100;
    localparam logic [8:0]  EOF_W      = 9'h101;
    localparam logic [8:0]  ERR_W      = 9'h103;
    localparam logic [10:0] MIN_LEN_C  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C  = 11'(MAX_LEN);
    localparam logic [3:0]  PEND_MAX_C = 4'(PEND_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_PAD,
        S_EOF,
        S_ERR,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        rr_last_q, rr_last_d;   // index of the requester granted most recently
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] cnt_inc;
    logic        len_err_q, len_err_d;   // ERR was entered through the length limit
    logic [3:0]  pending_q, pending_d;
    logic        start_q;

    // Granted requester's byte-stream signals
    logic        sel;
    logic [7:0]  g_data;
    logic        g_valid;
    logic        g_last;
    logic        g_abort;

    logic        wr_en;
    logic [8:0]  wr_d;
    logic        accept;
    logic        ctrl_wr;
    logic        win;

    assign sel     = grant_q[1];
    assign g_data  = sel ? d1_in : d0_in;
    assign g_valid = valid_in[sel];
    assign g_last  = last_in[sel];
    assign g_abort = abort_in[sel];
    assign cnt_inc = cnt_q + 11'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath-next logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        win       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((req_in != 2'b00) && (pending_q < PEND_MAX_C)) begin
                    if (req_in == 2'b11) begin
                        win = ~rr_last_q;
                    end else begin
                        win = req_in[1];
                    end
                    grant_d   = win ? 2'b10 : 2'b01;
                    rr_last_d = win;
                    state_d   = S_SOF;
                end
            end
            S_SOF: begin
                cnt_d     = '0;
                len_err_d = 1'b0;
                if (wr_en) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (g_abort) begin
                    state_d   = S_ERR;
                    len_err_d = 1'b0;
                end else if (accept) begin
                    cnt_d = cnt_inc;
                    if (g_last) begin
                        state_d = (cnt_inc < MIN_LEN_C) ? S_PAD : S_EOF;
                    end else if (cnt_inc == MAX_LEN_C) begin
                        state_d   = S_ERR;
                        len_err_d = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (wr_en) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MIN_LEN_C) begin
                        state_d = S_EOF;
                    end
                end
            end
            S_EOF: begin
                if (wr_en) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_ERR: begin
                if (wr_en) begin
                    if (len_err_q) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
            end
            S_DROP: begin
                if (accept && g_last) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // FIFO write word, write enable and byte-accept, decoded from the current state
    always_comb begin
        wr_en  = 1'b0;
        wr_d   = '0;
        accept = 1'b0;
        unique case (state_q)
            S_SOF: begin
                wr_d  = SOF_W;
                wr_en = !wr_full_in;
            end
            S_DATA: begin
                wr_d   = {1'b0, g_data};
                accept = g_valid && !g_abort && !wr_full_in;
                wr_en  = accept;
            end
            S_PAD: begin
                wr_d  = 9'h000;
                wr_en = !wr_full_in;
            end
            S_EOF: begin
                wr_d  = EOF_W;
                wr_en = !wr_full_in;
            end
            S_ERR: begin
                wr_d  = ERR_W;
                wr_en = !wr_full_in;
            end
            S_DROP: begin
                accept = g_valid;
            end
            default: begin
                wr_en  = 1'b0;
                accept = 1'b0;
            end
        endcase
    end

    assign wr_en_out = wr_en;
    assign wr_d_out  = wr_d;
    assign ack_out   = accept ? grant_q : 2'b00;

    // Pending frames: a frame terminator written and a SOF read in the same cycle cancel out
    assign ctrl_wr = wr_en && ((state_q == S_EOF) || (state_q == S_ERR));

    always_comb begin
        pending_d = pending_q;
        if (ctrl_wr && !mac_sof_rd_in) begin
            pending_d = pending_q + 4'd1;
        end else if (!ctrl_wr && mac_sof_rd_in && (pending_q != 4'd0)) begin
            pending_d = pending_q - 4'd1;
        end
    end

    // Grant, round-robin pointer, byte counter, pending count and MAC start
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q   <= '0;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            pending_q <= '0;
            start_q   <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
            pending_q <= pending_d;
            // Follows the count being loaded this edge so start rises the cycle after EOF
            start_q   <= (pending_d != 4'd0);
        end
    end

    assign grant_out     = grant_q;
    assign mac_start_out = start_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: randomized frame traffic against a frame-level reference model.
// The model turns each granted frame into its expected FIFO word list
// (SOF, data, zero pad, EOF/ERR), predicts grants round-robin and tracks the
// pending-frame count from the expected stream.
module tb_eth_tx_arb;

    localparam int MIN_LEN  = 60;
    localparam int MAX_LEN  = 1514;
    localparam int PEND_MAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_in = '0;
    logic [1:0] grant_out;
    logic [7:0] d0_in = '0;
    logic [7:0] d1_in = '0;
    logic [1:0] valid_in = '0;
    logic [1:0] last_in = '0;
    logic [1:0] abort_in = '0;
    logic [1:0] ack_out;
    logic       wr_en_out;
    logic [8:0] wr_d_out;
    logic       wr_full_in = 1'b0;
    logic       mac_sof_rd_in = 1'b0;
    logic       mac_start_out;

    always #5 clk = ~clk;

    eth_tx_arb #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .PEND_MAX(PEND_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .grant_out    (grant_out),
        .d0_in        (d0_in),
        .d1_in        (d1_in),
        .valid_in     (valid_in),
        .last_in      (last_in),
        .abort_in     (abort_in),
        .ack_out      (ack_out),
        .wr_en_out    (wr_en_out),
        .wr_d_out     (wr_d_out),
        .wr_full_in   (wr_full_in),
        .mac_sof_rd_in(mac_sof_rd_in),
        .mac_start_out(mac_start_out)
    );

    typedef struct {
        int         len;
        int         abort_at;   // -1: no abort
        logic [7:0] base;
        logic [7:0] step;
    } frame_t;

    int n_checks = 0;
    int n_errors = 0;

    // Driver side
    frame_t     fq [2][$];
    int         ptr [2];
    logic [1:0] prev_gnt = '0;
    int         full_mode = 0;  // 0 never, 1 random, 2 toggle
    int         sof_mode = 0;   // 0 never, 1 random, 2 on EOF write, 3 always

    // Reference model
    frame_t     mq [2][$];
    logic [8:0] exp_q [$];
    frame_t     m_cur;
    logic       m_busy = 1'b0;
    logic       m_drop = 1'b0;
    int         m_gnt = 0;
    int         m_last = 1;
    int         m_pend = 0;
    int         m_acks = 0;
    int         obs_log [$];
    logic [1:0] obs_prev = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fbyte(input frame_t f, input int i);
        return f.base + 8'(i) * f.step;
    endfunction

    task automatic add_frame(input int r, input int len, input int ab,
                             input logic [7:0] base, input logic [7:0] step);
        frame_t f;
        f.len = len; f.abort_at = ab; f.base = base; f.step = step;
        fq[r].push_back(f);
        mq[r].push_back(f);
    endtask

    task automatic add_random_frame(input int r, input int len, input int ab);
        add_frame(r, len, ab, 8'($urandom), 8'($urandom) | 8'h01);
    endtask

    task automatic build_expected(input frame_t f);
        int nd;
        exp_q.push_back(9'h100);
        nd = (f.abort_at >= 0) ? f.abort_at : ((f.len > MAX_LEN) ? MAX_LEN : f.len);
        for (int k = 0; k < nd; k++) exp_q.push_back({1'b0, fbyte(f, k)});
        if (f.abort_at >= 0 || f.len > MAX_LEN) begin
            exp_q.push_back(9'h103);
        end else begin
            for (int k = nd; k < MIN_LEN; k++) exp_q.push_back(9'h000);
            exp_q.push_back(9'h101);
        end
    endtask

    task automatic drive();
        frame_t     f;
        logic [7:0] d;
        logic       v, l, a;
        for (int i = 0; i < 2; i++) begin
            if (prev_gnt[i] && !grant_out[i]) begin
                if (fq[i].size() > 0) void'(fq[i].pop_front());
                ptr[i] = 0;
            end
            prev_gnt[i] = grant_out[i];
            req_in[i] = (fq[i].size() > 0);
            // Junk on the non-owning lane must be ignored by the arbiter
            v = 1'($urandom);
            l = 1'($urandom);
            a = ($urandom % 8 == 0);
            d = 8'($urandom);
            if (grant_out[i] && fq[i].size() > 0) begin
                f = fq[i][0];
                a = 1'b0;
                if (ptr[i] < f.len) begin
                    d = fbyte(f, ptr[i]);
                    l = (ptr[i] == f.len - 1);
                    if (f.abort_at == ptr[i]) begin
                        a = 1'b1;
                        v = 1'b1;
                    end else begin
                        v = ($urandom % 4 != 0);
                    end
                end
            end
            valid_in[i] = v;
            last_in[i]  = l;
            abort_in[i] = a;
            if (i == 0) d0_in = d; else d1_in = d;
        end
        case (full_mode)
            1: wr_full_in = ($urandom % 3 == 0);
            2: wr_full_in = ~wr_full_in;
            default: wr_full_in = 1'b0;
        endcase
        case (sof_mode)
            1: mac_sof_rd_in = ($urandom % 4 == 0);
            3: mac_sof_rd_in = 1'b1;
            default: mac_sof_rd_in = 1'b0;
        endcase
    endtask

    task automatic model_step();
        logic [1:0] gexp;
        logic       was_busy;
        logic       end_frame;
        logic       ctrl;
        logic [8:0] w;
        int         w_i;
        int         exp_acks;
        gexp = m_busy ? ((m_gnt == 1) ? 2'b10 : 2'b01) : 2'b00;
        check("grant", grant_out, gexp);
        check("mac_start", mac_start_out, m_pend != 0);
        check("ack_stray", ack_out & ~gexp, 0);
        if (wr_full_in) check("wr_when_full", wr_en_out, 0);
        if (grant_out != 2'b00 && obs_prev == 2'b00) obs_log.push_back(grant_out[1] ? 1 : 0);
        obs_prev = grant_out;

        was_busy  = m_busy;
        end_frame = 1'b0;
        ctrl      = 1'b0;
        if (m_busy && ack_out[m_gnt]) m_acks++;
        if (wr_en_out) begin
            if (exp_q.size() == 0) begin
                check("wr_extra", wr_d_out, 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("wr_d", wr_d_out, w);
                ctrl = (w == 9'h101) || (w == 9'h103);
                if (exp_q.size() == 0 && m_busy) begin
                    if (m_cur.abort_at < 0 && m_cur.len > MAX_LEN) m_drop = 1'b1;
                    else end_frame = 1'b1;
                end
            end
        end
        if (m_drop && m_acks == m_cur.len) end_frame = 1'b1;
        if (end_frame) begin
            exp_acks = (m_cur.abort_at >= 0) ? m_cur.abort_at : m_cur.len;
            check("acks", m_acks, exp_acks);
            m_busy = 1'b0;
            m_drop = 1'b0;
        end

        if (!was_busy && req_in != 2'b00 && m_pend < PEND_MAX) begin
            if (req_in == 2'b11) w_i = (m_last == 0) ? 1 : 0;
            else w_i = req_in[1] ? 1 : 0;
            if (mq[w_i].size() > 0) begin
                m_last = w_i;
                m_gnt  = w_i;
                m_busy = 1'b1;
                m_acks = 0;
                m_drop = 1'b0;
                m_cur  = mq[w_i].pop_front();
                build_expected(m_cur);
            end
        end

        if (ctrl && mac_sof_rd_in) begin
            // terminator written and SOF read together: count unchanged
        end else if (ctrl) begin
            m_pend++;
        end else if (mac_sof_rd_in && m_pend > 0) begin
            m_pend--;
        end
    endtask

    task automatic reset_step();
        check("rst_grant", grant_out, 0);
        check("rst_wr_en", wr_en_out, 0);
        check("rst_wr_d", wr_d_out, 0);
        check("rst_ack", ack_out, 0);
        check("rst_mac_start", mac_start_out, 0);
        m_busy = 1'b0; m_drop = 1'b0; m_pend = 0; m_last = 1; m_acks = 0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            fq[i].delete();
            mq[i].delete();
            ptr[i] = 0;
        end
        prev_gnt = '0;
        obs_prev = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        #1;
        if (sof_mode == 2) mac_sof_rd_in = wr_en_out && (wr_d_out == 9'h101);
        @(negedge clk);
        for (int i = 0; i < 2; i++) if (ack_out[i]) ptr[i]++;
        if (rst) reset_step(); else model_step();
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_until_done(input string tag, input int limit);
        int n = 0;
        while ((fq[0].size() + fq[1].size() != 0 || m_busy) && n < limit) begin
            cycle();
            n++;
        end
        check(tag, fq[0].size() + fq[1].size() + int'(m_busy), 0);
    endtask

    initial begin
        ptr[0] = 0;
        ptr[1] = 0;
        run_cycles(3);
        rst = 1'b0;

        // 64-byte frame 0x00..0x3F from requester 0, FIFO never full
        add_frame(0, 64, -1, 8'h00, 8'h01);
        run_until_done("done_64B", 400);

        // 10-byte frame from requester 1, padded to MIN_LEN
        add_random_frame(1, 10, -1);
        run_until_done("done_pad", 400);

        // Reset in the middle of a frame discards it and clears the pending count
        add_random_frame(1, 40, -1);
        run_cycles(20);
        rst = 1'b1;
        run_cycles(2);
        rst = 1'b0;
        run_cycles(2);

        // Both requesting, three frames each: grants must alternate from requester 0
        full_mode = 1;
        sof_mode  = 1;
        obs_log.delete();
        for (int k = 0; k < 3; k++) begin
            add_random_frame(0, 1 + int'($urandom % 80), -1);
            add_random_frame(1, 1 + int'($urandom % 80), -1);
        end
        run_until_done("done_rr", 2000);
        check("rr_count", obs_log.size(), 6);
        for (int k = 0; k < obs_log.size(); k++) check("rr_order", obs_log[k], k % 2);

        // Abort on the 5th byte, and abort coinciding with the last byte
        full_mode = 0;
        add_random_frame(0, 20, 4);
        add_random_frame(1, 8, 7);
        add_random_frame(0, 6, 0);
        run_until_done("done_abort", 600);

        // Length limit: over-long, exactly MAX_LEN, and one byte over
        full_mode = 1;
        add_random_frame(0, 1600, -1);
        add_random_frame(0, MAX_LEN, -1);
        add_random_frame(1, MAX_LEN + 1, -1);
        run_until_done("done_maxlen", 30000);

        // Random mix, including pad boundaries and aborts
        for (int k = 0; k < 30; k++) begin
            int r, len, ab;
            r   = int'($urandom % 10);
            len = (r < 6) ? 1 + int'($urandom % 70) : (r == 6) ? 59 : (r == 7) ? 60 :
                  (r == 8) ? 61 : 100 + int'($urandom % 100);
            ab  = ($urandom % 5 == 0) ? int'($urandom % len) : -1;
            add_random_frame(int'($urandom % 2), len, ab);
        end
        run_until_done("done_random", 20000);

        // FIFO full toggling every cycle, SOF read pulsed with the EOF write
        full_mode = 2;
        sof_mode  = 2;
        for (int k = 0; k < 4; k++) add_random_frame(int'($urandom % 2), 1 + int'($urandom % 80), -1);
        run_until_done("done_toggle", 2000);

        // Pending limit: with no SOF reads only PEND_MAX frames may start
        full_mode = 1;
        sof_mode  = 3;
        run_cycles(20);
        sof_mode = 0;
        for (int k = 0; k < 17; k++) add_random_frame(k % 2, 1, -1);
        run_cycles(2500);
        check("stall_left", fq[0].size() + fq[1].size(), 17 - PEND_MAX);
        sof_mode = 1;
        run_until_done("done_stall", 2000);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete (checks %0d errors %0d)", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
